// File: rtl/fifo_traffic_checker.sv
// rtl/fifo_traffic_checker.sv - FIFO fill/drain traffic generator and read-data checker
module fifo_traffic_checker #(
  parameter int DATA_W = 8,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_rd_en,
  output logic [1:0]        state,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              err_flag,
  output logic [31:0]       burst_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [DATA_W-1:0]  r_wr_data;
  logic [DATA_W-1:0]  r_exp_data;
  logic               r_rd_vld;
  logic [ERR_W-1:0]   r_err_cnt;
  logic               r_err_flag;
  logic [31:0]        r_burst_cnt;
  logic               w_drain_done;
  logic               w_mismatch;

  // Writes stop as soon as enable drops so the FILL->DRAIN cycle never writes;
  // both strobes are held low while rst is asserted.
  assign fifo_wr_en   = (r_state == ST_FILL) & ~fifo_full & enable & ~rst;
  assign fifo_rd_en   = (r_state == ST_DRAIN) & ~fifo_empty & ~rst;
  assign fifo_din     = r_wr_data;
  assign state        = r_state;
  assign err_cnt      = r_err_cnt;
  assign err_flag     = r_err_flag;
  assign burst_cnt    = r_burst_cnt;

  // DRAIN may only exit once the FIFO is empty and the last read's compare has landed.
  assign w_drain_done = (r_state == ST_DRAIN) & fifo_empty & ~r_rd_vld;
  assign w_mismatch   = r_rd_vld & (fifo_dout != r_exp_data);

  // Next-state selection for the fill/drain sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (enable) w_next = ST_FILL;
      ST_FILL:  if (fifo_full || !enable) w_next = ST_DRAIN;
      ST_DRAIN: if (w_drain_done) w_next = enable ? ST_FILL : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State register, data sequencers, checker and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wr_data   <= '0;
      r_exp_data  <= '0;
      r_rd_vld    <= 1'b0;
      r_err_cnt   <= '0;
      r_err_flag  <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      r_state  <= w_next;
      r_rd_vld <= fifo_rd_en;
      if (fifo_wr_en) r_wr_data <= r_wr_data + DATA_W'(1);
      if (r_rd_vld) r_exp_data <= r_exp_data + DATA_W'(1);
      if (w_mismatch) begin
        r_err_flag <= 1'b1;
        if (r_err_cnt != {ERR_W{1'b1}}) r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
      if (w_drain_done) r_burst_cnt <= r_burst_cnt + 32'd1;
    end
  end

endmodule
